mult_product_accumulator: RTL and testbench

Sequential stage directly downstream of the 4x4 unsigned multiplier core. It consumes one 8-bit product per beat over a valid/ready handshake and accumulates a frame of products, delimited by `in_last`, into a wide sum. It emits one registered result per frame with beat count and sticky overflow flag. Acts as the accumulate half of a streamed MAC: multiplier output in, dot-product result out.

---
 rtl/mult_product_accumulator_if.sv | 28 ++
 rtl/mult_product_accumulator.sv | 113 +++++++++++
 tb/tb_mult_product_accumulator.sv | 224 ++++++++++++++++++++++
 3 files changed

// File: rtl/mult_product_accumulator_if.sv
// Stream bundle between the multiplier core, this accumulator and the
// consumer of frame results. The slave side is the accumulator itself.
`timescale 1ns/1ps
interface mult_product_accumulator_if #(
  parameter int ACC_W = 16,
  parameter int CNT_W = 8
);
  logic             clear;
  logic             in_valid;
  logic             in_ready;
  logic [7:0]       in_prod;
  logic             in_last;
  logic             out_valid;
  logic             out_ready;
  logic [ACC_W-1:0] out_acc;
  logic [CNT_W-1:0] out_count;
  logic             out_ovf;

  modport slave (
    input  clear, in_valid, in_prod, in_last, out_ready,
    output in_ready, out_valid, out_acc, out_count, out_ovf
  );

  modport master (
    output clear, in_valid, in_prod, in_last, out_ready,
    input  in_ready, out_valid, out_acc, out_count, out_ovf
  );
endinterface

// File: rtl/mult_product_accumulator.sv
// Accumulates a last-delimited frame of 8-bit products into a wide sum and
// presents one registered result (sum, beat count, sticky overflow) per frame.
`timescale 1ns/1ps
module mult_product_accumulator #(
  parameter int ACC_W = 16,
  parameter int CNT_W = 8
) (
  input  logic                    clk,
  input  logic                    rst_n,
  mult_product_accumulator_if.slave bus
);

  typedef enum logic {IDLE = 1'b0, ACCUM = 1'b1} state_e;

  state_e           state_q, state_d;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             ovf_q, ovf_d;
  logic [ACC_W-1:0] res_acc_q, res_acc_d;
  logic [CNT_W-1:0] res_cnt_q, res_cnt_d;
  logic             res_ovf_q, res_ovf_d;
  logic             out_valid_q, out_valid_d;

  logic             in_ready;
  logic             beat_ok;
  logic [ACC_W:0]   sum;
  logic [ACC_W-1:0] acc_upd;
  logic [CNT_W-1:0] cnt_upd;
  logic             ovf_upd;

  // A full result register only blocks input while it is not being drained.
  assign in_ready = !out_valid_q || bus.out_ready;
  // A beat handshaken during clear is consumed but discarded.
  assign beat_ok  = bus.in_valid && in_ready && !bus.clear;

  // Running totals including the current beat; the extra sum bit is the carry.
  assign sum     = {1'b0, acc_q} + (ACC_W + 1)'(bus.in_prod);
  assign acc_upd = sum[ACC_W-1:0];
  assign ovf_upd = ovf_q | sum[ACC_W];
  assign cnt_upd = (&cnt_q) ? cnt_q : cnt_q + 1'b1;

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = out_valid_q;
  assign bus.out_acc   = res_acc_q;
  assign bus.out_count = res_cnt_q;
  assign bus.out_ovf   = res_ovf_q;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next state: a frame is open from its first accepted beat until last or clear.
  always_comb begin
    state_d = state_q;
    if (bus.clear)                  state_d = IDLE;
    else if (beat_ok && bus.in_last) state_d = IDLE;
    else if (beat_ok)               state_d = ACCUM;
  end

  // Datapath next values: accumulate, close a frame into the result, or abort.
  always_comb begin
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    ovf_d       = ovf_q;
    res_acc_d   = res_acc_q;
    res_cnt_d   = res_cnt_q;
    res_ovf_d   = res_ovf_q;
    out_valid_d = out_valid_q && !bus.out_ready;
    if (bus.clear) begin
      acc_d = '0;
      cnt_d = '0;
      ovf_d = 1'b0;
    end else if (beat_ok) begin
      if (bus.in_last) begin
        res_acc_d   = acc_upd;
        res_cnt_d   = cnt_upd;
        res_ovf_d   = ovf_upd;
        out_valid_d = 1'b1;
        acc_d       = '0;
        cnt_d       = '0;
        ovf_d       = 1'b0;
      end else begin
        acc_d = acc_upd;
        cnt_d = cnt_upd;
        ovf_d = ovf_upd;
      end
    end
  end

  // Accumulator and result registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q       <= '0;
      cnt_q       <= '0;
      ovf_q       <= 1'b0;
      res_acc_q   <= '0;
      res_cnt_q   <= '0;
      res_ovf_q   <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      ovf_q       <= ovf_d;
      res_acc_q   <= res_acc_d;
      res_cnt_q   <= res_cnt_d;
      res_ovf_q   <= res_ovf_d;
      out_valid_q <= out_valid_d;
    end
  end

endmodule

// File: tb/tb_mult_product_accumulator.sv
// Directed bench: the stimulus pushes hand-computed frame results into a
// queue, a monitor pops and compares on every result handshake.
`timescale 1ns/1ps
module tb_mult_product_accumulator;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  mult_product_accumulator_if #(.ACC_W(16), .CNT_W(8)) bus_if ();

  mult_product_accumulator #(.ACC_W(16), .CNT_W(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_if.slave)
  );

  typedef struct packed {
    logic [15:0] acc;
    logic [7:0]  cnt;
    logic        ovf;
  } res_t;

  res_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   hs_cnt = 0;

  // Count every input handshake (including ones dropped by clear).
  always @(posedge clk)
    if (rst_n && bus_if.in_valid && bus_if.in_ready) hs_cnt <= hs_cnt + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Offer one beat and hold it until accepted; returns the stall cycles.
  task automatic beat(input logic [7:0] p, input bit l, output int waits);
    bus_if.in_valid = 1'b1;
    bus_if.in_prod  = p;
    bus_if.in_last  = l;
    waits = 0;
    forever begin
      @(negedge clk);
      if (bus_if.in_ready) break;
      waits++;
      if (waits > 200) break;
    end
    @(posedge clk);
    #1;
    bus_if.in_valid = 1'b0;
    bus_if.in_last  = 1'b0;
    if (waits > 200) check("beat_accept_timeout", waits, 200);
    $display("beat prod=%02h last=%0d waits=%0d", p, l, waits);
  endtask

  task automatic frame_rep(input logic [7:0] p, input int n);
    int w;
    for (int i = 0; i < n; i++) beat(p, (i == n - 1), w);
  endtask

  // Monitor: compare each consumed result against the scoreboard head.
  initial begin : monitor
    res_t r;
    forever begin
      @(negedge clk);
      if (rst_n && bus_if.out_valid && bus_if.out_ready) begin
        if (exp_q.size() == 0) begin
          check("unexpected_result", 1, 0);
        end else begin
          r = exp_q.pop_front();
          check("res_acc", bus_if.out_acc, r.acc);
          check("res_count", bus_if.out_count, r.cnt);
          check("res_ovf", bus_if.out_ovf, r.ovf);
          $display("result acc=%0d count=%0d ovf=%0d", bus_if.out_acc, bus_if.out_count, bus_if.out_ovf);
        end
      end
    end
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin : stimulus
    int w;
    int hs_before;
    bus_if.clear     = 1'b0;
    bus_if.in_valid  = 1'b0;
    bus_if.in_prod   = 8'h00;
    bus_if.in_last   = 1'b0;
    bus_if.out_ready = 1'b1;

    // Reset state
    #12;
    check("rst_out_valid", bus_if.out_valid, 0);
    check("rst_out_acc", bus_if.out_acc, 0);
    check("rst_out_count", bus_if.out_count, 0);
    check("rst_out_ovf", bus_if.out_ovf, 0);
    check("rst_in_ready", bus_if.in_ready, 1);
    @(negedge clk);
    rst_n = 1'b1;
    idle(1);

    // Four beats of 15x15, result visible the cycle after the last beat
    exp_q.push_back('{acc: 16'h0384, cnt: 8'd4, ovf: 1'b0});
    frame_rep(8'hE1, 4);
    check("lat_out_valid", bus_if.out_valid, 1);
    check("lat_out_acc", bus_if.out_acc, 16'h0384);
    check("lat_out_count", bus_if.out_count, 4);
    check("lat_out_ovf", bus_if.out_ovf, 0);
    idle(2);

    // Stalled result, second frame offered during the stall
    bus_if.out_ready = 1'b0;
    exp_q.push_back('{acc: 16'h0384, cnt: 8'd4, ovf: 1'b0});
    frame_rep(8'hE1, 4);
    exp_q.push_back('{acc: 16'd6, cnt: 8'd3, ovf: 1'b0});
    hs_before = hs_cnt;
    fork
      begin
        beat(8'h01, 1'b0, w);
        beat(8'h02, 1'b0, w);
        beat(8'h03, 1'b1, w);
      end
      begin
        repeat (5) begin
          @(negedge clk);
          check("stall_out_valid", bus_if.out_valid, 1);
          check("stall_out_acc", bus_if.out_acc, 16'h0384);
          check("stall_out_count", bus_if.out_count, 4);
          check("stall_out_ovf", bus_if.out_ovf, 0);
          check("stall_in_ready", bus_if.in_ready, 0);
          check("stall_no_accept", hs_cnt, hs_before);
        end
        @(posedge clk);
        #1;
        bus_if.out_ready = 1'b1;
      end
    join
    check("stall_beats_accepted", hs_cnt - hs_before, 3);
    idle(2);

    // 292 beats of 0xE1: wraps, overflows, count saturates
    exp_q.push_back('{acc: 16'd164, cnt: 8'd255, ovf: 1'b1});
    frame_rep(8'hE1, 292);
    idle(2);

    // Back-to-back single-beat frames
    exp_q.push_back('{acc: 16'd9,   cnt: 8'd1, ovf: 1'b0});
    exp_q.push_back('{acc: 16'd0,   cnt: 8'd1, ovf: 1'b0});
    exp_q.push_back('{acc: 16'd255, cnt: 8'd1, ovf: 1'b0});
    beat(8'h09, 1'b1, w);
    check("b2b_waits_0", w, 0);
    beat(8'h00, 1'b1, w);
    check("b2b_waits_1", w, 0);
    beat(8'hFF, 1'b1, w);
    check("b2b_waits_2", w, 0);
    idle(2);

    // Clear aborts the frame and drops its own beat
    exp_q.push_back('{acc: 16'd5, cnt: 8'd1, ovf: 1'b0});
    beat(8'h10, 1'b0, w);
    beat(8'h10, 1'b0, w);
    bus_if.clear = 1'b1;
    beat(8'h20, 1'b0, w);
    bus_if.clear = 1'b0;
    beat(8'h05, 1'b1, w);
    idle(2);

    // Asynchronous reset mid-frame
    beat(8'h50, 1'b0, w);
    beat(8'h50, 1'b0, w);
    #2 rst_n = 1'b0;
    #1;
    check("midrst_out_valid", bus_if.out_valid, 0);
    check("midrst_out_acc", bus_if.out_acc, 0);
    check("midrst_in_ready", bus_if.in_ready, 1);
    @(negedge clk);
    rst_n = 1'b1;
    idle(1);
    exp_q.push_back('{acc: 16'd3, cnt: 8'd1, ovf: 1'b0});
    beat(8'h03, 1'b1, w);
    idle(2);

    // Asynchronous reset while a result is pending; that result is lost
    bus_if.out_ready = 1'b0;
    beat(8'h07, 1'b1, w);
    check("pend_out_valid", bus_if.out_valid, 1);
    check("pend_out_acc", bus_if.out_acc, 7);
    #2 rst_n = 1'b0;
    #1;
    check("pendrst_out_valid", bus_if.out_valid, 0);
    check("pendrst_out_acc", bus_if.out_acc, 0);
    check("pendrst_out_count", bus_if.out_count, 0);
    check("pendrst_out_ovf", bus_if.out_ovf, 0);
    check("pendrst_in_ready", bus_if.in_ready, 1);
    @(negedge clk);
    rst_n = 1'b1;
    bus_if.out_ready = 1'b1;
    idle(1);
    exp_q.push_back('{acc: 16'd3, cnt: 8'd1, ovf: 1'b0});
    beat(8'h03, 1'b1, w);

    // Wait (bounded) for the scoreboard to drain
    for (int i = 0; i < 20 && exp_q.size() != 0; i++) @(negedge clk);
    check("queue_drained", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
